// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types and helpers for the pattern scheduler
//  sched_state_t : scheduler FSM states (RUN shows a pattern, BLANK emits black frames)
//  grb_t         : one LED colour at the default 8-bit channel width, green in the MSBs
//  next_slot()   : round-robin successor of a slot index
package pattern_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        BLANK = 1'b1
    } sched_state_t;

    // Raw state constants, kept for blocks that hold the state in a plain logic vector.
    localparam logic [0:0] ST_RUN   = RUN;
    localparam logic [0:0] ST_BLANK = BLANK;

    localparam int DEFAULT_CW = 8;

    typedef struct packed {
        logic [DEFAULT_CW-1:0] green;
        logic [DEFAULT_CW-1:0] red;
        logic [DEFAULT_CW-1:0] blue;
    } grb_t;

    function automatic int unsigned next_slot(input int unsigned cur, input int unsigned num);
        return (cur + 1 >= num) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/pattern_color_mux.sv
// rtl/pattern_color_mux.sv - registered NUM_PATTERNS:1 colour mux with blank forcing and tag pipeline
//  clk_in, rst_n_in          clock, asynchronous active-low reset
//  req_valid/req_blank/req_slot  tag launched with each strand request
//  src_grb_in                per-slot {green,red,blue}, slot 0 in the LSBs
//  green_out/red_out/blue_out, color_ready  registered colour two cycles after the request
module pattern_color_mux
    import pattern_pkg::*;
#(
    parameter int NUM_PATTERNS = 4,
    parameter int COLOR_WIDTH  = 8,
    parameter int PAT_W        = 2
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic                                  req_valid,
    input  logic                                  req_blank,
    input  logic [PAT_W-1:0]                      req_slot,
    input  logic [NUM_PATTERNS*3*COLOR_WIDTH-1:0] src_grb_in,
    output logic [COLOR_WIDTH-1:0]                green_out,
    output logic [COLOR_WIDTH-1:0]                red_out,
    output logic [COLOR_WIDTH-1:0]                blue_out,
    output logic                                  color_ready
);

    localparam int GRB_W = 3 * COLOR_WIDTH;

    // First tag stage: lines up with the cycle in which the sources present their registered colour.
    logic             tag_valid;
    logic             tag_blank;
    logic [PAT_W-1:0] tag_slot;
    logic [GRB_W-1:0] sel_grb;

    always_comb begin
        sel_grb = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (tag_slot == PAT_W'(i)) begin
                sel_grb = src_grb_in[i*GRB_W +: GRB_W];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tag_valid   <= 1'b0;
            tag_blank   <= 1'b0;
            tag_slot    <= '0;
            color_ready <= 1'b0;
            green_out   <= '0;
            red_out     <= '0;
            blue_out    <= '0;
        end else begin
            tag_valid   <= req_valid;
            tag_blank   <= req_blank;
            tag_slot    <= req_slot;
            color_ready <= tag_valid;
            if (tag_valid && !tag_blank) begin
                {green_out, red_out, blue_out} <= sel_grb;
            end else begin
                {green_out, red_out, blue_out} <= '0;
            end
        end
    end

endmodule

// File: rtl/pattern_scheduler.sv
// rtl/pattern_scheduler.sv - shares one LED strand driver between NUM_PATTERNS pattern generators
//  clk_in, rst_n_in                      clock, asynchronous active-low reset
//  next_led_request, request_valid       strand driver request
//  auto_advance_in                       rotate every FRAMES_PER_PATTERN frames
//  sel_valid_in, sel_pattern_in          manual slot select strobe
//  src_led_request_out, src_request_valid_out  request fan-out, one-hot to the active slot
//  src_grb_in, src_color_ready_in        per-slot colour return
//  green_out/red_out/blue_out, color_ready  colour to strand driver, two cycles after request
//  active_pattern_out, frame_done_out    slot shown, one pulse per completed frame
module pattern_scheduler
    import pattern_pkg::*;
#(
    parameter  int NUM_PATTERNS       = 4,
    parameter  int NUM_LEDS           = 20,
    parameter  int FRAMES_PER_PATTERN = 500,
    parameter  int BLANK_FRAMES       = 2,
    parameter  int COLOR_WIDTH        = 8,
    localparam int LED_W              = $clog2(NUM_LEDS),
    localparam int PAT_W              = $clog2(NUM_PATTERNS)
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic [LED_W-1:0]                      next_led_request,
    input  logic                                  request_valid,
    input  logic                                  auto_advance_in,
    input  logic                                  sel_valid_in,
    input  logic [PAT_W-1:0]                      sel_pattern_in,
    output logic [LED_W-1:0]                      src_led_request_out,
    output logic [NUM_PATTERNS-1:0]               src_request_valid_out,
    input  logic [NUM_PATTERNS*3*COLOR_WIDTH-1:0] src_grb_in,
    input  logic [NUM_PATTERNS-1:0]               src_color_ready_in,
    output logic [COLOR_WIDTH-1:0]                green_out,
    output logic [COLOR_WIDTH-1:0]                red_out,
    output logic [COLOR_WIDTH-1:0]                blue_out,
    output logic                                  color_ready,
    output logic [PAT_W-1:0]                      active_pattern_out,
    output logic                                  frame_done_out
);

    localparam int FCW = $clog2(FRAMES_PER_PATTERN) + 1;
    localparam int BW  = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_PATTERN - 1);
    localparam logic [BW-1:0]  BLANK_LAST = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

    logic [0:0]       state;
    logic [PAT_W-1:0] active;
    logic [FCW-1:0]   frame_cnt;
    logic [BW-1:0]    blank_cnt;
    logic             pend_valid;
    logic [PAT_W-1:0] pend_slot;

    logic             frame_end;
    logic             sel_ok;
    logic             eff_pend;
    logic [PAT_W-1:0] eff_slot;
    logic [PAT_W-1:0] auto_slot;
    logic [PAT_W-1:0] target_slot;
    logic             unused_src_ready;

    // Colour qualifiers from the sources are not needed: the tag pipeline already knows when data is due.
    assign unused_src_ready = ^src_color_ready_in;

    assign frame_end = request_valid && (next_led_request == LED_W'(NUM_LEDS - 1));
    assign sel_ok    = sel_valid_in && ({{(32-PAT_W){1'b0}}, sel_pattern_in} < 32'(NUM_PATTERNS));

    // A strobe landing in the frame-end cycle counts for that boundary, so fold it in combinationally.
    assign eff_pend    = sel_ok || pend_valid;
    assign eff_slot    = sel_ok ? sel_pattern_in : pend_slot;
    assign auto_slot   = PAT_W'(next_slot(32'(active), NUM_PATTERNS));
    assign target_slot = eff_pend ? eff_slot : auto_slot;

    assign active_pattern_out  = active;
    assign src_led_request_out = rst_n_in ? next_led_request : '0;

    always_comb begin
        src_request_valid_out = '0;
        if (rst_n_in && request_valid && (state == ST_RUN)) begin
            for (int i = 0; i < NUM_PATTERNS; i++) begin
                if (active == PAT_W'(i)) begin
                    src_request_valid_out[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= ST_RUN;
            active         <= '0;
            frame_cnt      <= '0;
            blank_cnt      <= '0;
            pend_valid     <= 1'b0;
            pend_slot      <= '0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= frame_end;
            if (frame_end) begin
                pend_valid <= 1'b0;
                if (state == ST_RUN) begin
                    if (eff_pend || (auto_advance_in && (frame_cnt == FRAME_LAST))) begin
                        frame_cnt <= '0;
                        // Reselecting the slot already shown only restarts its frame count.
                        if (!(eff_pend && (eff_slot == active))) begin
                            active <= target_slot;
                            if (BLANK_FRAMES > 0) begin
                                state     <= ST_BLANK;
                                blank_cnt <= '0;
                            end
                        end
                    end else if (frame_cnt != FRAME_LAST) begin
                        frame_cnt <= frame_cnt + FCW'(1);
                    end
                end else begin
                    // A select arriving while blanking just retargets the upcoming slot.
                    if (eff_pend) begin
                        active <= eff_slot;
                    end
                    if (blank_cnt == BLANK_LAST) begin
                        state     <= ST_RUN;
                        blank_cnt <= '0;
                    end else begin
                        blank_cnt <= blank_cnt + BW'(1);
                    end
                end
            end else if (sel_ok) begin
                pend_valid <= 1'b1;
                pend_slot  <= sel_pattern_in;
            end
        end
    end

    pattern_color_mux #(
        .NUM_PATTERNS (NUM_PATTERNS),
        .COLOR_WIDTH  (COLOR_WIDTH),
        .PAT_W        (PAT_W)
    ) u_color_mux (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .req_valid   (request_valid),
        .req_blank   (state == ST_BLANK),
        .req_slot    (active),
        .src_grb_in  (src_grb_in),
        .green_out   (green_out),
        .red_out     (red_out),
        .blue_out    (blue_out),
        .color_ready (color_ready)
    );

endmodule

// File: tb/tb_pattern_scheduler.sv
// tb/tb_pattern_scheduler.sv - scoreboard bench for pattern_scheduler
module tb_pattern_scheduler;
    import pattern_pkg::*;

    localparam int NP  = 3;
    localparam int NL  = 4;
    localparam int FPP = 2;
    localparam int BF  = 1;
    localparam int CW  = 8;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [1:0]    next_led_request;
    logic          request_valid;
    logic          auto_advance_in;
    logic          sel_valid_in;
    logic [1:0]    sel_pattern_in;
    logic [1:0]    src_led_request_out;
    logic [NP-1:0] src_request_valid_out;
    logic [NP*3*CW-1:0] src_grb_in;
    logic [NP-1:0] src_color_ready_in;
    logic [CW-1:0] green_out, red_out, blue_out;
    logic          color_ready;
    logic [1:0]    active_pattern_out;
    logic          frame_done_out;

    pattern_scheduler #(
        .NUM_PATTERNS       (NP),
        .NUM_LEDS           (NL),
        .FRAMES_PER_PATTERN (FPP),
        .BLANK_FRAMES       (BF),
        .COLOR_WIDTH        (CW)
    ) dut (
        .clk_in                (clk_in),
        .rst_n_in              (rst_n_in),
        .next_led_request      (next_led_request),
        .request_valid         (request_valid),
        .auto_advance_in       (auto_advance_in),
        .sel_valid_in          (sel_valid_in),
        .sel_pattern_in        (sel_pattern_in),
        .src_led_request_out   (src_led_request_out),
        .src_request_valid_out (src_request_valid_out),
        .src_grb_in            (src_grb_in),
        .src_color_ready_in    (src_color_ready_in),
        .green_out             (green_out),
        .red_out               (red_out),
        .blue_out              (blue_out),
        .color_ready           (color_ready),
        .active_pattern_out    (active_pattern_out),
        .frame_done_out        (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Pattern sources: each slot registers its colour for the broadcast index one cycle later.
    grb_t color_tbl [NP][NL];

    always @(posedge clk_in) begin
        for (int s = 0; s < NP; s++) begin
            src_grb_in[s*24 +: 24] <= color_tbl[s][src_led_request_out];
            src_color_ready_in[s]  <= src_request_valid_out[s];
        end
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        int   act;
        logic fd;
        logic rdy;
    } cyc_t;

    logic [23:0] exp_color [$];
    cyc_t        exp_cycle [$];

    // Reference model: what is on screen, expressed as showing/blanking with a frame tally.
    bit m_blank;
    int m_slot, m_shown, m_blanks, m_ps;
    bit m_pv;
    bit prev_rv;

    task automatic model_reset();
        m_blank = 0; m_slot = 0; m_shown = 0; m_blanks = 0; m_pv = 0; m_ps = 0; prev_rv = 0;
    endtask

    task automatic cycle(input bit rv, input int idx, input bit autoa, input bit selv, input int sel);
        bit   fe;
        bit   sok;
        cyc_t c;
        @(negedge clk_in);
        request_valid    = rv;
        next_led_request = 2'(idx);
        auto_advance_in  = autoa;
        sel_valid_in     = selv;
        sel_pattern_in   = 2'(sel);
        #1;
        check("src_valid", 32'(src_request_valid_out), (rv && !m_blank) ? (32'd1 << m_slot) : 32'd0);
        check("src_index", 32'(src_led_request_out), 32'(idx));
        if (rv) exp_color.push_back(m_blank ? 24'h0 : color_tbl[m_slot][idx]);
        fe  = rv && (idx == NL - 1);
        sok = selv && (sel < NP);
        if (fe) begin
            if (sok) begin m_pv = 1; m_ps = sel; end
            if (!m_blank) begin
                if (m_pv) begin
                    m_pv = 0; m_shown = 0;
                    if (m_ps != m_slot) begin m_slot = m_ps; m_blank = (BF > 0); m_blanks = 0; end
                end else if (autoa && m_shown >= FPP - 1) begin
                    m_slot = (m_slot + 1) % NP; m_shown = 0; m_blank = (BF > 0); m_blanks = 0;
                end else begin
                    m_shown++;
                end
            end else begin
                if (m_pv) begin m_slot = m_ps; m_pv = 0; end
                m_blanks++;
                if (m_blanks >= BF) begin m_blank = 0; m_shown = 0; end
            end
        end else if (sok) begin
            m_pv = 1; m_ps = sel;
        end
        c.act = m_slot; c.fd = fe; c.rdy = prev_rv;
        exp_cycle.push_back(c);
        prev_rv = rv;
    endtask

    task automatic frame(input bit autoa, input int sel_at, input int sel);
        for (int i = 0; i < NL; i++) cycle(1'b1, i, autoa, (i == sel_at), (i == sel_at) ? sel : 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a colour, and per-cycle state after each drive.
    initial begin
        logic [23:0] e;
        cyc_t        c;
        forever begin
            @(posedge clk_in);
            #1;
            if (color_ready) begin
                if (exp_color.size() == 0) check("color_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_color.pop_front();
                    check("color", 32'({green_out, red_out, blue_out}), 32'(e));
                end
            end
            if (exp_cycle.size() > 0) begin
                c = exp_cycle.pop_front();
                check("active", 32'(active_pattern_out), 32'(c.act));
                check("frame_done", 32'(frame_done_out), 32'(c.fd));
                check("ready_latency", 32'(color_ready), 32'(c.rdy));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int led;
        bit rv;
        bit a;
        rst_n_in = 1'b0;
        request_valid = 0; next_led_request = 0; auto_advance_in = 0; sel_valid_in = 0; sel_pattern_in = 0;
        for (int s = 0; s < NP; s++)
            for (int i = 0; i < NL; i++) color_tbl[s][i] = grb_t'($urandom() | 32'h010101);
        color_tbl[0][2] = grb_t'(24'h112233);
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_color", 32'({green_out, red_out, blue_out}), 32'd0);
        check("reset_ready", 32'(color_ready), 32'd0);
        check("reset_active", 32'(active_pattern_out), 32'd0);
        check("reset_frame_done", 32'(frame_done_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Request for idx 2 on slot 0 returns 11/22/33 two cycles later.
        cycle(1, 0, 1, 0, 0); cycle(1, 1, 1, 0, 0); cycle(1, 2, 1, 0, 0); cycle(0, 0, 1, 0, 0);
        cycle(1, 3, 1, 0, 0);

        // Auto rotation with one blank frame between patterns, wrapping 2 -> 0.
        for (int f = 0; f < 18; f++) frame(1'b1, -1, 0);

        // Request gaps.
        led = 0;
        for (int k = 0; k < 60; k++) begin
            rv = ($urandom_range(0, 2) != 0);
            cycle(rv, led, 1'b1, 0, 0);
            if (rv) led = (led + 1) % NL;
        end
        while (led != 0) begin cycle(1, led, 1'b1, 0, 0); led = (led + 1) % NL; end

        // Manual select mid-frame, then an out-of-range slot, then reselect of the active slot.
        frame(1'b0, 1, 2);
        for (int f = 0; f < 3; f++) frame(1'b0, -1, 0);
        frame(1'b0, 1, 3);
        frame(1'b0, -1, 0);
        frame(1'b0, 2, 2);
        frame(1'b0, -1, 0);

        // Strobe coinciding with auto expiry on slot 0: manual target wins.
        frame(1'b0, 3, 0);
        frame(1'b0, -1, 0);
        frame(1'b0, -1, 0);
        frame(1'b1, 3, 2);
        frame(1'b1, -1, 0);
        frame(1'b1, -1, 0);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            if ((k % 200) == 0) a = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 19) == 0) led = $urandom_range(0, NL - 1);
            cycle(rv, led, a, ($urandom_range(0, 29) == 0), $urandom_range(0, 3));
            if (rv) led = (led + 1) % NL;
        end

        // Asynchronous reset between clock edges with traffic in flight.
        cycle(1, 1, 1, 0, 0);
        cycle(1, 2, 1, 0, 0);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        #1;
        check("async_color", 32'({green_out, red_out, blue_out}), 32'd0);
        check("async_ready", 32'(color_ready), 32'd0);
        check("async_active", 32'(active_pattern_out), 32'd0);
        check("async_frame_done", 32'(frame_done_out), 32'd0);
        check("async_src_valid", 32'(src_request_valid_out), 32'd0);
        exp_color.delete();
        exp_cycle.delete();
        model_reset();
        request_valid = 0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        for (int k = 0; k < 600; k++) begin
            rv = ($urandom_range(0, 9) < 9);
            cycle(rv, led, 1'b1, ($urandom_range(0, 39) == 0), $urandom_range(0, 3));
            if (rv) led = (led + 1) % NL;
        end

        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0);
        @(posedge clk_in);
        #2;
        check("drained", 32'(exp_color.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
